multicycle_datapath: RTL and testbench
======================================

# multicycle_datapath

Parametrised multi-cycle RISC-V integer datapath, the successor to the single-cycle `Datapath`. It executes an RV32I subset through a FETCH/DECODE/EXEC/MEM/WB state machine. Instruction fetch and data access share one memory port with a req/ready handshake, so memory may insert wait states. Width and register count are parametrised, and illegal, misaligned or `ebreak` instructions halt the core.

## Interface
- `XLEN`, 32: datapath and register width; 32 or 64.
- `ADDR_W`, 32: memory address and PC width; at most XLEN.
- `NUM_REGS`, 32: architectural registers; 32 (RV32I) or 16 (RV32E).
- `RESET_PC`, 0: PC loaded on reset; must be 4-aligned.
- `clock`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low (0 = reset).
- `mem_req`  out  1  memory request valid.
- `mem_we`  out  1  1 = write, 0 = read.
- `mem_addr`  out  ADDR_W  byte address.
- `mem_wdata`  out  XLEN  store data.
- `mem_rdata`  in  XLEN  read data; valid when `mem_req & mem_ready`.
- `mem_ready`  in  1  transfer completes at this edge.
- `halt`  out  1  core stopped; sticky until reset.
- `retired`  out  1  one-cycle pulse per completed instruction.
- `pc`  out  ADDR_W  PC of the instruction in flight.

## Operation
- **Supported instructions**
  - R-type (0110011): add, sub, and, or, slt.
  - I-type (0010011): addi, andi, ori.
  - lw/ld (0000011) and sw/sd (0100011): move one full XLEN word; funct3 is ignored.
  - beq, bne (1100011).
  - `ebreak` (0x00100073).
- **Halt conditions.** Any other opcode or funct combination, or any rs/rd index ≥ NUM_REGS, goes to HALT.
- **FETCH:** `mem_req=1`, `mem_we=0`, `mem_addr=PC`. On `mem_ready`: IR←`mem_rdata[31:0]`, OLDPC←PC, PC←PC+4 (wraps mod 2^ADDR_W), go to DECODE.
- **DECODE:**
  - A←rs1, B←rs2.
  - Immediate is sign-extended to XLEN.
  - TARGET←OLDPC+imm.
  - Illegal instruction or `ebreak` goes to HALT.
- **EXEC:**
  - ALU computes ALUOUT. Arithmetic wraps mod 2^XLEN; slt is a signed compare giving 0 or 1.
  - Branch resolves here and goes to FETCH with `retired`. If taken, PC←TARGET.
  - A taken target with `[1:0]≠0` goes to HALT instead.
  - Load/store go to MEM; R/I-type go to WB.
- **MEM:** `mem_addr=ALUOUT[ADDR_W-1:0]`, `mem_we` set for store, `mem_wdata=B`.
  - An address not aligned to XLEN/8 goes to HALT with no request issued.
  - A load captures MDR and goes to WB.
  - A store pulses `retired` and goes to FETCH.
- **WB:** rd←(load ? MDR : ALUOUT), pulse `retired`, go to FETCH. Writes to x0 are discarded; x0 always reads 0.
- **HALT:** `halt=1`, `mem_req=0`. Absorbing until reset.
- **Handshake rules:**
  - While `mem_req=1`, `mem_addr`, `mem_we` and `mem_wdata` stay stable until the edge where `mem_ready=1`.
  - `mem_ready` is ignored when `mem_req=0`.
  - Ready in the first request cycle means zero wait states.

## Timing
- **Reset (async assert):**
  - `mem_req=0`, `mem_we=0`, `halt=0`, `retired=0`.
  - PC=RESET_PC, state=FETCH, all registers 0.
  - Any in-flight transfer is abandoned immediately.
- **After deassert:** FETCH drives `mem_req=1` in the first cycle.
- **Cycles per instruction at zero wait:** branch 3, R/I-type 4, store 4, load 5. Each memory wait cycle adds 1.
- **`retired` timing:** asserted during the final-state cycle (EXEC for branch, MEM for store, WB otherwise).
- **`pc` output:** equals OLDPC from DECODE onward, and equals PC during FETCH.
- **Register file:** combinational read, write at the WB edge. A value written in WB is visible to the next instruction's DECODE.

## Structure
- Package `multicycle_pkg`:
  - State enum (FETCH, DECODE, EXEC, MEM, WB, HALT).
  - Opcode and funct3/funct7 constants.
  - ALU operation enum.
  - `EBREAK` constant.
- Sub-module `register_file`, parametrised by XLEN and NUM_REGS: two read ports, one write port, x0 hardwired to 0.
- ALU and immediate generation stay inline.

## Test plan
- **Reset vector:** RESET_PC=0x100, reset released, mem_ready=1 → first request has `mem_addr=0x100`, `mem_we=0`; `retired` never asserts before the fetch completes.
- **ALU sequence:** `addi x1,x0,5; addi x2,x0,-3; add x3,x1,x2; slt x4,x2,x1` → x3=2, x4=1, four `retired` pulses spaced 4 cycles apart.
- **Load/store with waits:** `sw x3,8(x0)`, then `lw x5,8(x0)`, with mem_ready held low 2 cycles per access → write at addr 8 with data 2, x5=2, signals stable during the waits, load takes 7 cycles.
- **Branch and x0:** `beq x0,x0,-4` loops with PC repeating every 3 cycles. `bne x0,x0,8` falls through to PC+4. `addi x0,x0,7` leaves x0=0.
- **Halt cases:** `ebreak`, opcode 0x7F, and `lw x1,2(x0)` with XLEN=32 → each gives `halt=1`, `mem_req=0`, and no further requests until reset.
- **Reset mid-access:** reset asserted during a load wait → `mem_req` drops the same cycle; after release, fetch restarts from RESET_PC.

Source files
------------

// File: rtl/multicycle_pkg.sv
// Shared types and encodings for the multi-cycle RV32I-subset datapath.
// Covers FSM states, opcode/funct fields, ALU operations and the ALU-op decode helper.
package multicycle_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } alu_op_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  localparam logic [31:0] EBREAK = 32'h0010_0073;

  // Legality is checked separately; this only picks the operation.
  function automatic alu_op_t alu_op_of(input logic [6:0] op, input logic [2:0] f3,
                                        input logic [6:0] f7);
    alu_op_t res;
    res = ALU_ADD;
    if (op == OP_R || op == OP_I) begin
      case (f3)
        F3_AND:  res = ALU_AND;
        F3_OR:   res = ALU_OR;
        F3_SLT:  res = (op == OP_R) ? ALU_SLT : ALU_ADD;
        default: res = (op == OP_R && f7 == F7_SUB) ? ALU_SUB : ALU_ADD;
      endcase
    end
    return res;
  endfunction

endpackage

// File: rtl/multicycle_datapath_register_file.sv
// Architectural register file: two combinational read ports, one write port.
// Entry 0 is never written, so x0 always reads zero.
module register_file
  #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32
  )
  (
    input  logic            clock,
    input  logic            reset,
    input  logic            i_we,
    input  logic [4:0]      i_waddr,
    input  logic [XLEN-1:0] i_wdata,
    input  logic [4:0]      i_raddr1,
    input  logic [4:0]      i_raddr2,
    output logic [XLEN-1:0] o_rdata1,
    output logic [XLEN-1:0] o_rdata2
  );

  localparam int AW = $clog2(NUM_REGS);

  logic [XLEN-1:0] r_regs [NUM_REGS];
  logic [AW-1:0]   w_waddr;
  logic [AW-1:0]   w_raddr1;
  logic [AW-1:0]   w_raddr2;

  assign w_waddr  = i_waddr[AW-1:0];
  assign w_raddr1 = i_raddr1[AW-1:0];
  assign w_raddr2 = i_raddr2[AW-1:0];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (i_we && w_waddr != '0) begin
      r_regs[w_waddr] <= i_wdata;
    end
  end

  assign o_rdata1 = (w_raddr1 == '0) ? '0 : r_regs[w_raddr1];
  assign o_rdata2 = (w_raddr2 == '0) ? '0 : r_regs[w_raddr2];

endmodule

// File: rtl/multicycle_datapath.sv
// Multi-cycle RV32I-subset core sharing one req/ready memory port for fetch and data.
//   state  | meaning
//   FETCH  | request instruction at PC, latch IR/OLDPC, PC += 4
//   DECODE | read rs1/rs2, form branch target, reject illegal/ebreak
//   EXEC   | ALU op or branch resolve (branch retires here)
//   MEM    | load/store transfer at ALUOUT (store retires here)
//   WB     | write rd, retire
//   HALT   | stopped until reset
module multicycle_datapath
  import multicycle_pkg::*;
  #(
    parameter int              XLEN     = 32,
    parameter int              ADDR_W   = 32,
    parameter int              NUM_REGS = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
  )
  (
    input  logic              clock,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic [XLEN-1:0]   mem_rdata,
    input  logic              mem_ready,
    output logic              halt,
    output logic              retired,
    output logic [ADDR_W-1:0] pc
  );

  localparam int BYTE_LSB = $clog2(XLEN / 8);

  state_t            r_state;
  state_t            w_next;
  logic [31:0]       r_ir;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_oldpc;
  logic [ADDR_W-1:0] r_target;
  logic [XLEN-1:0]   r_a;
  logic [XLEN-1:0]   r_b;
  logic [XLEN-1:0]   r_aluout;
  logic [XLEN-1:0]   r_mdr;

  logic [6:0]      w_opcode;
  logic [4:0]      w_rd;
  logic [2:0]      w_f3;
  logic [4:0]      w_rs1;
  logic [4:0]      w_rs2;
  logic [6:0]      w_f7;
  logic            w_is_r;
  logic            w_is_i;
  logic            w_is_load;
  logic            w_is_store;
  logic            w_is_branch;
  logic            w_legal;
  logic            w_ok;
  logic            w_rd_bad;
  logic            w_rs1_bad;
  logic            w_rs2_bad;
  logic [XLEN-1:0] w_imm;
  logic [XLEN-1:0] w_opb;
  logic [XLEN-1:0] w_alu_res;
  alu_op_t         w_alu_op;
  logic            w_taken;
  logic            w_br_bad;
  logic            w_misaligned;
  logic [XLEN-1:0] w_rdata1;
  logic [XLEN-1:0] w_rdata2;
  logic            w_rf_we;
  logic [XLEN-1:0] w_rf_wdata;

  assign w_opcode    = r_ir[6:0];
  assign w_rd        = r_ir[11:7];
  assign w_f3        = r_ir[14:12];
  assign w_rs1       = r_ir[19:15];
  assign w_rs2       = r_ir[24:20];
  assign w_f7        = r_ir[31:25];
  assign w_is_r      = (w_opcode == OP_R);
  assign w_is_i      = (w_opcode == OP_I);
  assign w_is_load   = (w_opcode == OP_LOAD);
  assign w_is_store  = (w_opcode == OP_STORE);
  assign w_is_branch = (w_opcode == OP_BRANCH);

  always_comb begin
    w_legal = 1'b0;
    case (w_opcode)
      OP_R: begin
        if (w_f7 == F7_BASE)
          w_legal = (w_f3 == F3_ADD) || (w_f3 == F3_AND) || (w_f3 == F3_OR) || (w_f3 == F3_SLT);
        else if (w_f7 == F7_SUB)
          w_legal = (w_f3 == F3_ADD);
      end
      OP_I:               w_legal = (w_f3 == F3_ADD) || (w_f3 == F3_AND) || (w_f3 == F3_OR);
      OP_LOAD, OP_STORE:  w_legal = 1'b1;
      OP_BRANCH:          w_legal = (w_f3 == F3_BEQ) || (w_f3 == F3_BNE);
      default:            w_legal = 1'b0;  // ebreak lands here too
    endcase
  end

  // Only register fields the format actually uses are range-checked.
  assign w_rd_bad  = ({1'b0, w_rd}  >= 6'(NUM_REGS));
  assign w_rs1_bad = ({1'b0, w_rs1} >= 6'(NUM_REGS));
  assign w_rs2_bad = ({1'b0, w_rs2} >= 6'(NUM_REGS));
  assign w_ok = w_legal && !w_rs1_bad
             && !((w_is_r || w_is_i || w_is_load) && w_rd_bad)
             && !((w_is_r || w_is_store || w_is_branch) && w_rs2_bad);

  always_comb begin
    w_imm = {{(XLEN-12){r_ir[31]}}, r_ir[31:20]};
    if (w_is_store)
      w_imm = {{(XLEN-12){r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
    else if (w_is_branch)
      w_imm = {{(XLEN-13){r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
  end

  assign w_alu_op = alu_op_of(w_opcode, w_f3, w_f7);
  assign w_opb    = w_is_r ? r_b : w_imm;

  always_comb begin
    w_alu_res = r_a + w_opb;
    case (w_alu_op)
      ALU_SUB: w_alu_res = r_a - w_opb;
      ALU_AND: w_alu_res = r_a & w_opb;
      ALU_OR:  w_alu_res = r_a | w_opb;
      ALU_SLT: w_alu_res = {{(XLEN-1){1'b0}}, ($signed(r_a) < $signed(w_opb))};
      default: w_alu_res = r_a + w_opb;
    endcase
  end

  assign w_taken      = (w_f3 == F3_BEQ) ? (r_a == r_b) : (r_a != r_b);
  assign w_br_bad     = w_taken && (r_target[1:0] != 2'b00);
  assign w_misaligned = |r_aluout[BYTE_LSB-1:0];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:  if (mem_ready) w_next = S_DECODE;
      S_DECODE: w_next = w_ok ? S_EXEC : S_HALT;
      S_EXEC: begin
        if (w_is_branch)                  w_next = w_br_bad ? S_HALT : S_FETCH;
        else if (w_is_load || w_is_store) w_next = S_MEM;
        else                              w_next = S_WB;
      end
      S_MEM: begin
        if (w_misaligned)   w_next = S_HALT;
        else if (mem_ready) w_next = w_is_load ? S_WB : S_FETCH;
      end
      S_WB:     w_next = S_FETCH;
      S_HALT:   w_next = S_HALT;
      default:  w_next = S_HALT;
    endcase
  end

  // mem_req is gated by reset so an in-flight transfer is dropped the moment reset asserts.
  always_comb begin
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    mem_addr = r_pc;
    retired  = 1'b0;
    halt     = 1'b0;
    pc       = r_oldpc;
    case (r_state)
      S_FETCH: begin
        mem_req = reset;
        pc      = r_pc;
      end
      S_EXEC:  retired = w_is_branch && !w_br_bad;
      S_MEM: begin
        mem_req  = reset && !w_misaligned;
        mem_we   = reset && !w_misaligned && w_is_store;
        mem_addr = r_aluout[ADDR_W-1:0];
        retired  = w_is_store && !w_misaligned && mem_ready;
      end
      S_WB:    retired = 1'b1;
      S_HALT:  halt = 1'b1;
      default: halt = 1'b0;
    endcase
  end

  assign mem_wdata = r_b;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pc     <= RESET_PC;
      r_oldpc  <= '0;
      r_ir     <= '0;
      r_target <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_aluout <= '0;
      r_mdr    <= '0;
    end else begin
      case (r_state)
        S_FETCH: if (mem_ready) begin
          r_ir    <= mem_rdata[31:0];
          r_oldpc <= r_pc;
          r_pc    <= r_pc + ADDR_W'(4);
        end
        S_DECODE: begin
          r_a      <= w_rdata1;
          r_b      <= w_rdata2;
          r_target <= r_oldpc + w_imm[ADDR_W-1:0];
        end
        S_EXEC: begin
          r_aluout <= w_alu_res;
          if (w_is_branch && w_taken && !w_br_bad) r_pc <= r_target;
        end
        S_MEM: if (mem_ready && !w_misaligned && w_is_load) r_mdr <= mem_rdata;
        default: ;
      endcase
    end
  end

  assign w_rf_we    = (r_state == S_WB);
  assign w_rf_wdata = w_is_load ? r_mdr : r_aluout;

  register_file #(.XLEN(XLEN), .NUM_REGS(NUM_REGS)) u_rf (
    .clock    (clock),
    .reset    (reset),
    .i_we     (w_rf_we),
    .i_waddr  (w_rd),
    .i_wdata  (w_rf_wdata),
    .i_raddr1 (w_rs1),
    .i_raddr2 (w_rs2),
    .o_rdata1 (w_rdata1),
    .o_rdata2 (w_rdata2)
  );

endmodule

// File: tb/tb_multicycle_datapath.sv
// Directed bench for multicycle_datapath: small programs with hand-computed results.
// Program memory sits at 0x100+, data memory below 0x100 with configurable wait states.
module tb_multicycle_datapath;

  logic        clock;
  logic        reset;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        halt;
  logic        retired;
  logic [31:0] pc;

  int n_run  = 0;
  int n_fail = 0;

  logic [31:0] pmem [64];
  logic [31:0] dmem [16];
  int          wait_data = 0;

  int          cyc, rcnt, req_cyc, dreq, wcnt, st_cnt, stab_err;
  logic [31:0] st_addr, st_data;
  logic [31:0] ret_cyc [16];
  logic [31:0] ret_pc  [16];
  logic        pv_hold, pv_we;
  logic [31:0] pv_addr, pv_wdata;

  multicycle_datapath #(.XLEN(32), .ADDR_W(32), .NUM_REGS(32), .RESET_PC(32'h100)) dut (
    .clock     (clock),
    .reset     (reset),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .halt      (halt),
    .retired   (retired),
    .pc        (pc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign mem_ready = mem_req && ((mem_addr >= 32'h100) || (wcnt >= wait_data));
  assign mem_rdata = (mem_addr < 32'h100) ? dmem[mem_addr[5:2]] : pmem[mem_addr[7:2]];

  always_ff @(posedge clock) begin
    if (!reset) begin
      cyc <= 0; rcnt <= 0; req_cyc <= 0; dreq <= 0; wcnt <= 0;
      st_cnt <= 0; stab_err <= 0; pv_hold <= 1'b0;
    end else begin
      cyc <= cyc + 1;
      if (retired && rcnt < 16) begin
        ret_cyc[rcnt] <= cyc;
        ret_pc[rcnt]  <= pc;
        rcnt          <= rcnt + 1;
      end
      if (mem_req) req_cyc <= req_cyc + 1;
      if (mem_req && mem_addr < 32'h100) dreq <= dreq + 1;
      wcnt <= (mem_req && !mem_ready) ? wcnt + 1 : 0;
      if (mem_req && mem_ready && mem_we) begin
        st_cnt <= st_cnt + 1;
        st_addr <= mem_addr;
        st_data <= mem_wdata;
        dmem[mem_addr[5:2]] <= mem_wdata;
      end
      pv_hold  <= mem_req && !mem_ready;
      pv_addr  <= mem_addr;
      pv_we    <= mem_we;
      pv_wdata <= mem_wdata;
      if (pv_hold && (!mem_req || mem_addr != pv_addr || mem_we != pv_we || mem_wdata != pv_wdata))
        stab_err <= stab_err + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  task automatic clear_prog();
    for (int i = 0; i < 64; i++) pmem[i] = 32'h0010_0073;
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic wait_halt(input string tag, input int max);
    for (int i = 0; i < max; i++) begin
      if (halt) break;
      @(negedge clock);
    end
    chk(tag, halt, 1);
  endtask

  task automatic wait_rcnt(input string tag, input int n, input int max);
    for (int i = 0; i < max; i++) begin
      if (rcnt >= n) break;
      @(negedge clock);
    end
    chk(tag, (rcnt >= n), 1);
  endtask

  task automatic halt_case(input string tag, input logic [31:0] instr);
    int snap;
    clear_prog();
    pmem[0] = instr;
    pulse_reset();
    wait_halt({tag, "_halt"}, 50);
    chk({tag, "_req0"}, mem_req, 0);
    snap = req_cyc;
    repeat (10) @(negedge clock);
    chk({tag, "_no_more_req"}, req_cyc, snap);
    chk({tag, "_sticky"}, halt, 1);
    chk({tag, "_no_retire"}, rcnt, 0);
  endtask

  initial begin
    reset = 1'b0;
    clear_prog();

    // Reset vector
    repeat (3) @(negedge clock);
    #1;
    chk("rst_req", mem_req, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_halt", halt, 0);
    chk("rst_retired", retired, 0);
    chk("rst_pc", pc, 32'h100);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("first_req", mem_req, 1);
    chk("first_addr", mem_addr, 32'h100);
    chk("first_we", mem_we, 0);
    chk("first_retired", retired, 0);

    // ALU sequence
    clear_prog();
    pmem[0] = enc_i(12'd5,   5'd0, 3'b000, 5'd1, 7'b0010011);
    pmem[1] = enc_i(12'hFFD, 5'd0, 3'b000, 5'd2, 7'b0010011);
    pmem[2] = enc_r(7'b0, 5'd2, 5'd1, 3'b000, 5'd3);
    pmem[3] = enc_r(7'b0, 5'd1, 5'd2, 3'b010, 5'd4);
    pulse_reset();
    wait_halt("alu_halt", 200);
    chk("alu_x1", dut.u_rf.r_regs[1], 32'd5);
    chk("alu_x2", dut.u_rf.r_regs[2], 32'hFFFF_FFFD);
    chk("alu_x3", dut.u_rf.r_regs[3], 32'd2);
    chk("alu_x4", dut.u_rf.r_regs[4], 32'd1);
    chk("alu_rcnt", rcnt, 4);
    chk("alu_gap1", ret_cyc[1] - ret_cyc[0], 4);
    chk("alu_gap2", ret_cyc[2] - ret_cyc[1], 4);
    chk("alu_gap3", ret_cyc[3] - ret_cyc[2], 4);

    // Load/store with two data wait states
    clear_prog();
    wait_data = 2;
    pmem[0] = enc_i(12'd2, 5'd0, 3'b000, 5'd3, 7'b0010011);
    pmem[1] = enc_s(12'd8, 5'd3, 5'd0);
    pmem[2] = enc_i(12'd8, 5'd0, 3'b010, 5'd5, 7'b0000011);
    pulse_reset();
    wait_halt("ls_halt", 200);
    chk("ls_st_cnt", st_cnt, 1);
    chk("ls_st_addr", st_addr, 32'd8);
    chk("ls_st_data", st_data, 32'd2);
    chk("ls_x5", dut.u_rf.r_regs[5], 32'd2);
    chk("ls_rcnt", rcnt, 3);
    chk("ls_store_gap", ret_cyc[1] - ret_cyc[0], 6);
    chk("ls_load_gap", ret_cyc[2] - ret_cyc[1], 7);
    chk("ls_stable", stab_err, 0);
    wait_data = 0;

    // Branch loop and x0
    clear_prog();
    pmem[0] = enc_i(12'd7, 5'd0, 3'b000, 5'd0, 7'b0010011);
    pmem[1] = enc_b(13'd8, 5'd0, 5'd0, 3'b001);
    pmem[2] = enc_b(13'h1FFC, 5'd0, 5'd0, 3'b000);
    pulse_reset();
    wait_rcnt("br_progress", 5, 100);
    chk("br_pc0", ret_pc[0], 32'h100);
    chk("br_pc1", ret_pc[1], 32'h104);
    chk("br_pc2", ret_pc[2], 32'h108);
    chk("br_pc3", ret_pc[3], 32'h104);
    chk("br_pc4", ret_pc[4], 32'h108);
    chk("br_gap1", ret_cyc[1] - ret_cyc[0], 3);
    chk("br_gap2", ret_cyc[2] - ret_cyc[1], 3);
    chk("br_gap3", ret_cyc[3] - ret_cyc[2], 3);
    chk("br_gap4", ret_cyc[4] - ret_cyc[3], 3);
    chk("br_x0", dut.u_rf.r_regs[0], 32'd0);
    chk("br_no_halt", halt, 0);

    // Halt cases
    halt_case("h_ebreak", 32'h0010_0073);
    halt_case("h_op7f", 32'h0000_007F);
    halt_case("h_lw_mis", enc_i(12'd2, 5'd0, 3'b010, 5'd1, 7'b0000011));
    chk("h_lw_mis_no_dreq", dreq, 0);

    // Reset during a load wait
    clear_prog();
    wait_data = 2;
    pmem[0] = enc_i(12'd8, 5'd0, 3'b010, 5'd5, 7'b0000011);
    pulse_reset();
    for (int i = 0; i < 20; i++) begin
      if (mem_req && mem_addr == 32'd8) break;
      @(negedge clock);
    end
    chk("mid_found_load", (mem_req && mem_addr == 32'd8), 1);
    reset = 1'b0;
    #1;
    chk("mid_req_drop", mem_req, 0);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("mid_restart_req", mem_req, 1);
    chk("mid_restart_addr", mem_addr, 32'h100);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1);
  end

endmodule
